// File: rtl/mvm_seq_ctrl.sv
// Sequencer for the matrix-vector multiply unit.
// Loads matrix A and vector X from one input stream, then walks each row of A against X.
// While it walks, it drives the external MAC's clear/accumulate strobes, then presents each
// dot product on the output stream.
// Optional feature: define MVM_KEEP_MATRIX_EN to keep A resident after the first job.
// In that build every later job streams only the N words of X.
module mvm_seq_ctrl #(
    parameter int unsigned M        = 4,
    parameter int unsigned N        = 4,
    parameter int unsigned A_ADDR_W = 4,
    parameter int unsigned X_ADDR_W = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                s_valid,
    output logic                s_ready,
    output logic                m_valid,
    input  logic                m_ready,
    output logic                wr_en_a,
    output logic                wr_en_x,
    output logic [A_ADDR_W-1:0] addr_a,
    output logic [X_ADDR_W-1:0] addr_x,
    output logic                clear_acc,
    output logic                en_acc,
    output logic                done
);

    typedef enum logic [2:0] {
        StLoadA,
        StLoadX,
        StCompute,
        StDrain,
        StOutput
    } state_e;

    localparam logic [A_ADDR_W-1:0] LastA    = A_ADDR_W'(M * N - 1);
    localparam logic [A_ADDR_W-1:0] LastXCnt = A_ADDR_W'(N - 1);
    localparam logic [A_ADDR_W-1:0] LastRow  = A_ADDR_W'(M - 1);
    localparam logic [A_ADDR_W-1:0] RowStep  = A_ADDR_W'(N);
    localparam logic [X_ADDR_W-1:0] LastCol  = X_ADDR_W'(N - 1);

    state_e                state_q;
    logic [A_ADDR_W-1:0]   cnt_q;          // load beat counter, shared by A and X loads
    logic [A_ADDR_W-1:0]   row_q;
    logic [A_ADDR_W-1:0]   base_q;         // row_q * N, kept incrementally
    logic [X_ADDR_W-1:0]   col_q;
    logic                  rd_q;           // a memory read was issued last cycle
    logic                  first_q;        // that read was column 0
    logic [A_ADDR_W-1:0]   addr_a_hold_q;  // last driven addresses, held outside active states
    logic [X_ADDR_W-1:0]   addr_x_hold_q;

    // Sequencer state, counters and the read-pipeline flags aligned to the 1-cycle memory read.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= StLoadA;
            cnt_q         <= '0;
            row_q         <= '0;
            base_q        <= '0;
            col_q         <= '0;
            rd_q          <= 1'b0;
            first_q       <= 1'b0;
            addr_a_hold_q <= '0;
            addr_x_hold_q <= '0;
        end else begin
            rd_q          <= (state_q == StCompute);
            first_q       <= (state_q == StCompute) && (col_q == '0);
            addr_a_hold_q <= addr_a;
            addr_x_hold_q <= addr_x;
            unique case (state_q)
                StLoadA: begin
                    if (s_valid) begin
                        if (cnt_q == LastA) begin
                            cnt_q   <= '0;
                            state_q <= StLoadX;
                        end else begin
                            cnt_q <= cnt_q + A_ADDR_W'(1);
                        end
                    end
                end
                StLoadX: begin
                    if (s_valid) begin
                        if (cnt_q == LastXCnt) begin
                            cnt_q   <= '0;
                            row_q   <= '0;
                            base_q  <= '0;
                            col_q   <= '0;
                            state_q <= StCompute;
                        end else begin
                            cnt_q <= cnt_q + A_ADDR_W'(1);
                        end
                    end
                end
                StCompute: begin
                    if (col_q == LastCol) begin
                        col_q   <= '0;
                        state_q <= StDrain;
                    end else begin
                        col_q <= col_q + X_ADDR_W'(1);
                    end
                end
                StDrain: begin
                    state_q <= StOutput;
                end
                StOutput: begin
                    if (m_ready) begin
                        if (row_q == LastRow) begin
`ifdef MVM_KEEP_MATRIX_EN
                            state_q <= StLoadX;
`else
                            state_q <= StLoadA;
`endif
                        end else begin
                            row_q   <= row_q + A_ADDR_W'(1);
                            base_q  <= base_q + RowStep;
                            col_q   <= '0;
                            state_q <= StCompute;
                        end
                    end
                end
                default: begin
                    state_q <= StLoadA;
                end
            endcase
        end
    end

    // Outputs decoded from the registered state; write enables and done follow the handshakes.
    always_comb begin
        s_ready   = (state_q == StLoadA) || (state_q == StLoadX);
        wr_en_a   = (state_q == StLoadA) && s_valid;
        wr_en_x   = (state_q == StLoadX) && s_valid;
        m_valid   = (state_q == StOutput);
        done      = (state_q == StOutput) && m_ready && (row_q == LastRow);
        clear_acc = rd_q && first_q;
        en_acc    = rd_q && !first_q;
        addr_a    = addr_a_hold_q;
        addr_x    = addr_x_hold_q;
        if (state_q == StLoadA) begin
            addr_a = cnt_q;
        end
        if (state_q == StLoadX) begin
            addr_x = cnt_q[X_ADDR_W-1:0];
        end
        if (state_q == StCompute) begin
            addr_a = base_q + A_ADDR_W'(col_q);
            addr_x = col_q;
        end
    end

endmodule

// File: doc/mvm_seq_ctrl.md
# mvm_seq_ctrl

Top-level sequencer for the matrix-vector multiply unit. It drives the matrix memory (A) and vector memory (X) write/address ports from one AXI-style input stream. It then steps the read addresses and MAC accumulate controls row by row, and presents each dot product to an AXI-style output stream. The memories have a 1-cycle synchronous read. The MAC register is external and controlled only by `clear_acc` and `en_acc`.

## Interface
Parameters:
- `M`, default 4: matrix rows (≥1).
- `N`, default 4: matrix columns and vector length (≥2).
- `A_ADDR_W`, default 4: A address width, ≥ clog2(M*N).
- `X_ADDR_W`, default 2: X address width, ≥ clog2(N).

Ports:
- `clk`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `s_valid`  in  1  input stream data valid.
- `s_ready`  out  1  input stream ready.
- `m_valid`  out  1  output stream valid (accumulator holds a result).
- `m_ready`  in  1  output stream ready.
- `wr_en_a`  out  1  A memory write enable.
- `wr_en_x`  out  1  X memory write enable.
- `addr_a`  out  A_ADDR_W  A memory address (write or read).
- `addr_x`  out  X_ADDR_W  X memory address (write or read).
- `clear_acc`  out  1  MAC: acc <= product (first term of a row).
- `en_acc`  out  1  MAC: acc <= acc + product.
- `done`  out  1  one-cycle pulse when the last row of a job is accepted.

## Operation
States:
- LOAD_A: `s_ready`=1. `wr_en_a` = `s_valid`. `addr_a` = load count (0..M*N-1), which increments on each write. The write at M*N-1 goes to LOAD_X and resets the count to 0.
- LOAD_X: `s_ready`=1. `wr_en_x` = `s_valid`. `addr_x` = count (0..N-1). The write at N-1 goes to COMPUTE with row=0 and col=0.
- COMPUTE: `addr_a` = row*N+col and `addr_x` = col. col increments every cycle with no stall. Leaving col=N-1 goes to DRAIN.
- DRAIN: one cycle. Applies the last term's accumulate.
- OUTPUT: `m_valid`=1 and held until `m_ready`. When `m_valid`&`m_ready`:
  - if row<M-1: row++, col=0, go to COMPUTE;
  - else: pulse `done` and go to LOAD_A (or see Configuration).

Read-pipeline alignment:
- A registered flag `rd_d` is 1 for the cycle after each COMPUTE cycle, and `first_d` marks col=0.
- `en_acc` = `rd_d` & ~`first_d`.
- `clear_acc` = `rd_d` & `first_d`.
- `clear_acc` and `en_acc` are never both 1.

Outputs outside their own states:
- `s_ready`, `wr_en_a`, `wr_en_x` = 0 outside LOAD_A and LOAD_X.
- `m_valid` = 0 outside OUTPUT.
- Outside COMPUTE and LOAD states, `addr_a` and `addr_x` hold their last value.

Input and width rules:
- `s_valid` is ignored outside LOAD states. `m_ready` is ignored outside OUTPUT.
- row*N+col is computed at A_ADDR_W width and never exceeds M*N-1.
- All counters wrap only by explicit reset to 0, never by overflow.

## Timing
- Reset (async, any state, including mid-load or mid-compute):
  - state=LOAD_A; all counters, `rd_d` and `first_d` = 0.
  - Outputs: `s_ready`=1 (LOAD_A), `m_valid`=0, `wr_en_a`=0, `wr_en_x`=0, `clear_acc`=0, `en_acc`=0, `done`=0, `addr_a`=0, `addr_x`=0.
- Load takes one beat per accepted handshake. Gaps in `s_valid` stall the count.
- Per row, from entering COMPUTE: N COMPUTE cycles, then 1 DRAIN cycle, then OUTPUT. `m_valid` rises N+1 cycles after COMPUTE entry.
- `clear_acc` is asserted in COMPUTE cycle 2 (the cycle after col=0). The last `en_acc` is asserted in DRAIN.
- Output backpressure: OUTPUT holds indefinitely and the accumulator is untouched (`clear_acc`=`en_acc`=0).
- Back-to-back: with `m_ready`=1, the next row's COMPUTE starts the cycle after acceptance. Row period = N+2 cycles.
- After the last acceptance: `s_ready`=1 on the next cycle. `done` is asserted in the acceptance cycle.

## Configuration
- `MVM_KEEP_MATRIX_EN` defined: after the first job, the last-row acceptance goes to LOAD_X instead of LOAD_A. A is loaded only once after reset and reused, so each later job streams N words.
- Not defined: every job reloads A then X (M*N+N input words per job).
- Reset always returns to LOAD_A in both builds.

## Test plan
- Reset mid-COMPUTE (row 2, col 1) → next cycle: state LOAD_A, `s_ready`=1, `addr_a`=0, `m_valid`=0, `en_acc`=0.
- M=N=4, `s_valid` held 1, A=1..16, x=[1,1,1,1] → `wr_en_a` on 16 cycles and `wr_en_x` on 4. Outputs y=10,26,42,58. `m_valid` arrives 5 cycles after each COMPUTE entry. `done` with y=58.
- `s_valid` toggling 1,0,1,0 during load → exactly one write per high beat. Addresses 0..15 with no skips or repeats.
- `m_ready`=0 for 7 cycles on row 1 → `m_valid` held 7 cycles, no `clear_acc`/`en_acc`, row stays 1. Accepted on the 8th cycle.
- Two consecutive jobs with `m_ready`=1, then x=[2,0,0,0] → second job y=2,10,18,26. With `MVM_KEEP_MATRIX_EN`, only 4 input words are accepted, and `wr_en_a` is never asserted in job 2.
- Alignment check, per row: `clear_acc` exactly once, `en_acc` exactly N-1 times, never both high, the last one in DRAIN.
